// File: rtl/pc_sequencer_if.sv
// ---------------------------------------------------------------------------
// pc_sequencer_if
// Bundles the signals between the control unit / cache miss logic (master)
// and the PC sequencer (slave).
//
// Master drives: PCSrc, ImmExt, ALUResult, icache_stall, dcache_stall,
//                ext_redirect, ext_addr
// Slave drives:  PC, PC_plus4, pc_valid, redirect_pend, misalign, bad_addr,
//                instret, stall_cnt
// Parameter CNT_W sets the width of the two performance counters.
// ---------------------------------------------------------------------------
interface pc_sequencer_if #(
   parameter int CNT_W = 32
);
   logic [1:0]       PCSrc;
   logic [31:0]      ImmExt;
   logic [31:0]      ALUResult;
   logic             icache_stall;
   logic             dcache_stall;
   logic             ext_redirect;
   logic [31:0]      ext_addr;
   logic [31:0]      PC;
   logic [31:0]      PC_plus4;
   logic             pc_valid;
   logic             redirect_pend;
   logic             misalign;
   logic [31:0]      bad_addr;
   logic [CNT_W-1:0] instret;
   logic [CNT_W-1:0] stall_cnt;

   modport master (
      output PCSrc, ImmExt, ALUResult, icache_stall, dcache_stall,
             ext_redirect, ext_addr,
      input  PC, PC_plus4, pc_valid, redirect_pend, misalign, bad_addr,
             instret, stall_cnt
   );

   modport slave (
      input  PCSrc, ImmExt, ALUResult, icache_stall, dcache_stall,
             ext_redirect, ext_addr,
      output PC, PC_plus4, pc_valid, redirect_pend, misalign, bad_addr,
             instret, stall_cnt
   );
endinterface

// File: rtl/pc_sequencer.sv
// ---------------------------------------------------------------------------
// pc_sequencer
// Owns the program counter of the single-cycle core. Picks the next PC from
// PCSrc, freezes while either cache is stalled, queues external redirects
// that arrive during a stall, and counts retired instructions and stall
// cycles.
//
// Ports:
//   clk  - core clock, all state changes on the rising edge
//   rst  - synchronous active-high reset
//   bus  - pc_sequencer_if.slave (control inputs in, PC/status/counters out)
//
// Optional feature macro: PC_MISALIGN_TRAP_EN
//   defined   - a load of a target with bits [1:0] != 0 goes to TRAP_VECTOR,
//               pulses misalign and records the target in bad_addr
//   undefined - loaded targets are forced word aligned, misalign/bad_addr
//               read as zero
// ---------------------------------------------------------------------------
module pc_sequencer #(
   parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
   parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0100,
   parameter int          CNT_W        = 32
) (
   input logic           clk,
   input logic           rst,
   pc_sequencer_if.slave bus
);

   typedef enum logic [1:0] {
      BOOT = 2'd0,
      RUN  = 2'd1,
      PEND = 2'd2
   } state_t;

   state_t           r_state;
   state_t           w_nextState;
   logic [31:0]      r_pc;
   logic [31:0]      r_pend;
   logic [CNT_W-1:0] r_instret;
   logic [CNT_W-1:0] r_stallCnt;

   logic             w_stall;
   logic [31:0]      w_cand;
   logic [31:0]      w_target;
   logic             w_load;
   logic             w_retire;
   logic             w_stallInc;
   logic             w_latchPend;

   assign w_stall = bus.icache_stall | bus.dcache_stall;

   // Sequential next-PC candidate; 11 is treated like 00 (fall through).
   always_comb begin
      w_cand = r_pc + 32'd4;
      case (bus.PCSrc)
         2'b01:   w_cand = r_pc + bus.ImmExt;
         2'b10:   w_cand = bus.ALUResult;
         default: w_cand = r_pc + 32'd4;
      endcase
   end

   // Next-state and datapath control. A redirect always beats PCSrc, and a
   // redirected target never counts as a retired instruction.
   always_comb begin
      w_nextState = r_state;
      w_load      = 1'b0;
      w_target    = r_pc;
      w_retire    = 1'b0;
      w_stallInc  = 1'b0;
      w_latchPend = 1'b0;
      case (r_state)
         BOOT: begin
            w_nextState = RUN;
         end
         RUN: begin
            if (!w_stall) begin
               w_load   = 1'b1;
               w_target = bus.ext_redirect ? bus.ext_addr : w_cand;
               w_retire = !bus.ext_redirect;
            end else begin
               w_stallInc = 1'b1;
               if (bus.ext_redirect) begin
                  w_latchPend = 1'b1;
                  w_nextState = PEND;
               end
            end
         end
         PEND: begin
            if (w_stall) begin
               w_stallInc  = 1'b1;
               w_latchPend = bus.ext_redirect;
            end else begin
               w_load      = 1'b1;
               w_target    = bus.ext_redirect ? bus.ext_addr : r_pend;
               w_nextState = RUN;
            end
         end
         default: begin
            w_nextState = BOOT;
         end
      endcase
   end

`ifdef PC_MISALIGN_TRAP_EN
   logic        r_misalign;
   logic [31:0] r_badAddr;
`endif

   // State, PC, pending redirect and counters. Counters wrap naturally.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= BOOT;
         r_pc       <= RESET_VECTOR;
         r_pend     <= 32'h0;
         r_instret  <= '0;
         r_stallCnt <= '0;
`ifdef PC_MISALIGN_TRAP_EN
         r_misalign <= 1'b0;
         r_badAddr  <= 32'h0;
`endif
      end else begin
         r_state <= w_nextState;
         if (w_latchPend)
            r_pend <= bus.ext_addr;
         if (w_stallInc)
            r_stallCnt <= r_stallCnt + CNT_W'(1);
`ifdef PC_MISALIGN_TRAP_EN
         r_misalign <= 1'b0;
         if (w_load) begin
            if (w_target[1:0] != 2'b00) begin
               r_pc       <= TRAP_VECTOR;
               r_misalign <= 1'b1;
               r_badAddr  <= w_target;
            end else begin
               r_pc <= w_target;
               if (w_retire)
                  r_instret <= r_instret + CNT_W'(1);
            end
         end
`else
         if (w_load) begin
            r_pc <= w_target & 32'hFFFF_FFFC;
            if (w_retire)
               r_instret <= r_instret + CNT_W'(1);
         end
`endif
      end
   end

   assign bus.PC            = r_pc;
   assign bus.PC_plus4      = r_pc + 32'd4;
   assign bus.pc_valid      = (r_state != BOOT);
   assign bus.redirect_pend = (r_state == PEND);
   assign bus.instret       = r_instret;
   assign bus.stall_cnt     = r_stallCnt;
`ifdef PC_MISALIGN_TRAP_EN
   assign bus.misalign      = r_misalign;
   assign bus.bad_addr      = r_badAddr;
`else
   assign bus.misalign      = 1'b0;
   assign bus.bad_addr      = 32'h0;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// ---------------------------------------------------------------------------
// tb_pc_sequencer
// Directed bench for pc_sequencer. Inputs change 1 time unit after a rising
// edge and outputs are sampled at the same point, so every check sees the
// state produced by the preceding edge.
// ---------------------------------------------------------------------------
module tb_pc_sequencer;

   logic clk;
   logic rst;
   int   checkCount;
   int   failCount;

   pc_sequencer_if #(.CNT_W(32)) bus ();

   pc_sequencer #(
      .RESET_VECTOR(32'h0000_0000),
      .TRAP_VECTOR (32'h0000_0100),
      .CNT_W       (32)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   // Free-running 10 time-unit clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Single comparison point: counts every check and reports mismatches.
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checkCount++;
      if (observed !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, observed, expected);
      end
   endtask

   // Drive one cycle of inputs, then advance to just after the next edge.
   task automatic applyStimulus(input logic [1:0] pcSrc, input logic [31:0] imm,
                                input logic [31:0] alu, input logic iStall,
                                input logic dStall, input logic redir,
                                input logic [31:0] redirAddr);
      bus.PCSrc        = pcSrc;
      bus.ImmExt       = imm;
      bus.ALUResult    = alu;
      bus.icache_stall = iStall;
      bus.dcache_stall = dStall;
      bus.ext_redirect = redir;
      bus.ext_addr     = redirAddr;
      @(posedge clk);
      #1;
   endtask

   // Directed sequence with hand-computed expectations.
   initial begin
      checkCount = 0;
      failCount  = 0;
      rst = 1'b1;
      bus.PCSrc = 2'b00; bus.ImmExt = '0; bus.ALUResult = '0;
      bus.icache_stall = 1'b0; bus.dcache_stall = 1'b0;
      bus.ext_redirect = 1'b0; bus.ext_addr = '0;

      applyStimulus(2'b00, 0, 0, 0, 0, 0, 0);
      applyStimulus(2'b00, 0, 0, 1, 1, 1, 32'h44);
      checkOutput("rst_pc", bus.PC, 32'h0);
      checkOutput("rst_valid", 32'(bus.pc_valid), 32'd0);
      checkOutput("rst_pend", 32'(bus.redirect_pend), 32'd0);
      checkOutput("rst_misalign", 32'(bus.misalign), 32'd0);
      checkOutput("rst_badaddr", bus.bad_addr, 32'h0);
      checkOutput("rst_instret", bus.instret, 32'd0);
      checkOutput("rst_stallcnt", bus.stall_cnt, 32'd0);

      // Boot then sequential fetch: 0, 0, 4, 8.
      rst = 1'b0;
      checkOutput("boot_pc", bus.PC, 32'h0);
      checkOutput("boot_valid", 32'(bus.pc_valid), 32'd0);
      applyStimulus(2'b00, 0, 0, 0, 0, 0, 0);
      checkOutput("run_pc0", bus.PC, 32'h0);
      checkOutput("run_valid", 32'(bus.pc_valid), 32'd1);
      applyStimulus(2'b00, 0, 0, 0, 0, 0, 0);
      checkOutput("seq_pc4", bus.PC, 32'h4);
      checkOutput("seq_plus4", bus.PC_plus4, 32'h8);
      applyStimulus(2'b11, 0, 0, 0, 0, 0, 0);
      checkOutput("seq_pc8", bus.PC, 32'h8);
      checkOutput("seq_instret", bus.instret, 32'd2);

      // Redirect without stall to 0x20; not retired.
      applyStimulus(2'b01, 32'h40, 0, 0, 0, 1, 32'h20);
      checkOutput("redir_pc", bus.PC, 32'h20);
      checkOutput("redir_instret", bus.instret, 32'd2);

      // Branch backwards, then JALR.
      applyStimulus(2'b01, 32'hFFFF_FFF0, 0, 0, 0, 0, 0);
      checkOutput("branch_pc", bus.PC, 32'h10);
      applyStimulus(2'b10, 0, 32'h400, 0, 0, 0, 0);
      checkOutput("jalr_pc", bus.PC, 32'h400);
      checkOutput("jalr_instret", bus.instret, 32'd4);
      applyStimulus(2'b10, 0, 32'h40, 0, 0, 0, 0);
      checkOutput("jalr_pc40", bus.PC, 32'h40);

      // Instruction-cache stall for 4 cycles holds the PC.
      for (int i = 0; i < 4; i++)
         applyStimulus(2'b01, 32'h100, 32'h0, 1, 0, 0, 0);
      checkOutput("istall_pc", bus.PC, 32'h40);
      checkOutput("istall_cnt", bus.stall_cnt, 32'd4);
      checkOutput("istall_instret", bus.instret, 32'd5);
      applyStimulus(2'b00, 0, 0, 0, 0, 0, 0);
      checkOutput("istall_release_pc", bus.PC, 32'h44);
      checkOutput("istall_release_instret", bus.instret, 32'd6);

      // Redirects queued during a data-cache stall; latest wins.
      applyStimulus(2'b00, 0, 0, 0, 1, 1, 32'h800);
      checkOutput("pend_set", 32'(bus.redirect_pend), 32'd1);
      checkOutput("pend_pc_hold", bus.PC, 32'h44);
      applyStimulus(2'b00, 0, 0, 0, 1, 0, 0);
      checkOutput("pend_still", 32'(bus.redirect_pend), 32'd1);
      applyStimulus(2'b10, 0, 32'h123, 0, 1, 1, 32'h900);
      checkOutput("pend_pc_hold2", bus.PC, 32'h44);
      checkOutput("pend_stallcnt", bus.stall_cnt, 32'd7);
      applyStimulus(2'b10, 0, 32'h123, 0, 0, 0, 0);
      checkOutput("pend_release_pc", bus.PC, 32'h900);
      checkOutput("pend_release_flag", 32'(bus.redirect_pend), 32'd0);
      checkOutput("pend_release_instret", bus.instret, 32'd6);
      checkOutput("pend_release_stallcnt", bus.stall_cnt, 32'd7);

      // Reset while a redirect is pending.
      applyStimulus(2'b00, 0, 0, 0, 1, 1, 32'hA00);
      checkOutput("pend2_set", 32'(bus.redirect_pend), 32'd1);
      rst = 1'b1;
      applyStimulus(2'b00, 0, 0, 0, 1, 0, 0);
      rst = 1'b0;
      checkOutput("pendrst_pc", bus.PC, 32'h0);
      checkOutput("pendrst_flag", 32'(bus.redirect_pend), 32'd0);
      checkOutput("pendrst_instret", bus.instret, 32'd0);
      checkOutput("pendrst_stallcnt", bus.stall_cnt, 32'd0);
      checkOutput("pendrst_valid", 32'(bus.pc_valid), 32'd0);

      // BOOT ignores stall inputs; then the misaligned JALR target.
      applyStimulus(2'b10, 0, 32'h500, 1, 0, 0, 0);
      checkOutput("boot2_pc", bus.PC, 32'h0);
      checkOutput("boot2_stallcnt", bus.stall_cnt, 32'd0);
      applyStimulus(2'b10, 0, 32'h102, 0, 0, 0, 0);
      checkOutput("mis_pc", bus.PC, 32'h100);
`ifdef PC_MISALIGN_TRAP_EN
      checkOutput("mis_pulse", 32'(bus.misalign), 32'd1);
      checkOutput("mis_badaddr", bus.bad_addr, 32'h102);
      checkOutput("mis_instret", bus.instret, 32'd0);
`else
      checkOutput("mis_pulse", 32'(bus.misalign), 32'd0);
      checkOutput("mis_badaddr", bus.bad_addr, 32'h0);
      checkOutput("mis_instret", bus.instret, 32'd1);
`endif
      applyStimulus(2'b00, 0, 0, 0, 0, 0, 0);
      checkOutput("mis_after_pc", bus.PC, 32'h104);
      checkOutput("mis_after_pulse", 32'(bus.misalign), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
      $finish;
   end

endmodule
